// File: rtl/vga_pkg.sv
// Shared VGA timing constants and coordinate type for the timing generator, colour mapper and game logic.
// Combinational only: no latency, no backpressure.
package vga_pkg;

    localparam int CLK_DIV_DEF   = 2;
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Both scan totals have to fit the 10-bit coordinate counters.
    function automatic bit timing_fits(input int h_total, input int v_total);
        return (h_total <= (1 << COORD_W)) && (v_total <= (1 << COORD_W));
    endfunction

    localparam bit DEFAULTS_FIT = timing_fits(H_TOTAL, V_TOTAL);

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL scan counter with wrap flag plus active-region and sync-region decode of the current count.
// Count advances on the cycle en is high; decodes are combinational; no backpressure.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int VISIBLE    = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_LEN   = 96
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t cnt,
    output logic   wrap,
    output logic   active,
    output logic   in_sync
);

    localparam coord_t LAST = coord_t'(TOTAL - 1);
    localparam coord_t VIS  = coord_t'(VISIBLE);
    localparam coord_t SS   = coord_t'(SYNC_START);
    // One bit wider so a sync region ending exactly at TOTAL=1024 still compares correctly.
    localparam logic [COORD_W:0] SE = (COORD_W+1)'(SYNC_START + SYNC_LEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + coord_t'(1);
        end
    end

    assign wrap    = (cnt == LAST);
    assign active  = (cnt < VIS);
    assign in_sync = (cnt >= SS) && ({1'b0, cnt} < SE);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: DrawX/DrawY scan out, HS/VS/BLANK_N/RGB pins registered one pixel behind the scan; no backpressure.
// VGA_FRAME_COUNT_EN adds a 16-bit frame_count that steps with every vblank_start pulse.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       vblank_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    if (!timing_fits(HT, VT)) begin : g_totals_too_large
        $error("vga_timing_gen: scan totals exceed 10-bit counters");
    end
    if ((CLK_DIV < 2) || (CLK_DIV % 2 != 0)) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be even and at least 2");
    end

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_cnt_next;
    logic          pe;
    coord_t        hc, vc;
    logic          h_wrap, v_wrap;
    logic          h_active, v_active;
    logic          h_sync, v_sync;
    logic          visible;

    assign pe           = (div_cnt == DIV_LAST);
    assign div_cnt_next = pe ? '0 : div_cnt + DW'(1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_cnt <= '0;
            VGA_CLK <= 1'b0;
        end else begin
            div_cnt <= div_cnt_next;
            VGA_CLK <= (div_cnt_next >= DIV_HALF);
        end
    end

    vga_axis_counter #(
        .TOTAL(HT), .VISIBLE(H_VISIBLE),
        .SYNC_START(H_VISIBLE + H_FRONT), .SYNC_LEN(H_SYNC)
    ) u_h_cnt (
        .clk(Clk), .rst(Reset), .en(pe),
        .cnt(hc), .wrap(h_wrap), .active(h_active), .in_sync(h_sync)
    );

    vga_axis_counter #(
        .TOTAL(VT), .VISIBLE(V_VISIBLE),
        .SYNC_START(V_VISIBLE + V_FRONT), .SYNC_LEN(V_SYNC)
    ) u_v_cnt (
        .clk(Clk), .rst(Reset), .en(pe && h_wrap),
        .cnt(vc), .wrap(v_wrap), .active(v_active), .in_sync(v_sync)
    );

    assign DrawX      = hc;
    assign DrawY      = vc;
    assign visible    = h_active && v_active;
    assign VGA_SYNC_N = 1'b0;

    // Syncs, blank and colour all come from the same pre-increment hc/vc so the DAC sees them aligned.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
        end else if (pe) begin
            VGA_HS      <= !h_sync;
            VGA_VS      <= !v_sync;
            VGA_BLANK_N <= visible;
            VGA_R       <= visible ? Red_in   : 8'h00;
            VGA_G       <= visible ? Green_in : 8'h00;
            VGA_B       <= visible ? Blue_in  : 8'h00;
        end
    end

    assign vblank_start = pe && h_wrap && (vc == coord_t'(V_VISIBLE - 1));

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_count <= 16'h0000;
        end else if (vblank_start) begin
            frame_count <= frame_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen at a shrunken raster, compared each cycle against a pixel-index reference model.
module tb_vga_timing_gen;

    localparam int CLK_DIV  = 2;
    localparam int H_VIS    = 16;
    localparam int H_FP     = 4;
    localparam int H_SW     = 6;
    localparam int H_BP     = 6;
    localparam int V_VIS    = 10;
    localparam int V_FP     = 2;
    localparam int V_SW     = 2;
    localparam int V_BP     = 3;
    localparam int H_TOT    = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT    = V_VIS + V_FP + V_SW + V_BP;
    localparam int FRAME    = H_TOT * V_TOT;
    localparam int HS_START = H_VIS + H_FP;
    localparam int VS_START = V_VIS + V_FP;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] Red_in = 8'h00;
    logic [7:0] Green_in = 8'h00;
    logic [7:0] Blue_in = 8'h00;
    logic [9:0] DrawX, DrawY;
    logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       vblank_start;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    always #5 Clk = ~Clk;

    vga_timing_gen #(
        .CLK_DIV(CLK_DIV),
        .H_VISIBLE(H_VIS), .H_FRONT(H_FP), .H_SYNC(H_SW), .H_BACK(H_BP),
        .V_VISIBLE(V_VIS), .V_FRONT(V_FP), .V_SYNC(V_SW), .V_BACK(V_BP)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in),
        .DrawX(DrawX), .DrawY(DrawY),
        .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .vblank_start(vblank_start)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(frame_count)
`endif
    );

    int checks = 0;
    int passed = 0;

    // Reference model: t = Clk edges since reset release; pixel n = t/CLK_DIV in raster order.
    int         t;
    logic       e_hs, e_vs, e_blank, e_vblank, prev_vblank;
    logic [7:0] e_r, e_g, e_b;
    int         e_fc;

    task automatic model_reset();
        t = 0;
        e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0;
        e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
        e_vblank = 1'b0; prev_vblank = 1'b0;
        e_fc = 0;
    endtask

    task automatic drive_rand();
        Red_in   = 8'($urandom);
        Green_in = 8'($urandom);
        Blue_in  = 8'($urandom);
    endtask

    // One Clk edge of the model; pins describe the pixel that was current when the last pixel period ended.
    task automatic tick();
        int p, px, py;
        @(posedge Clk);
        t++;
        if (prev_vblank) e_fc = (e_fc + 1) % 65536;
        if (t % CLK_DIV == 0) begin
            p  = (t / CLK_DIV - 1) % FRAME;
            px = p % H_TOT;
            py = p / H_TOT;
            e_hs    = !(px >= HS_START && px < HS_START + H_SW);
            e_vs    = !(py >= VS_START && py < VS_START + V_SW);
            e_blank = (px < H_VIS) && (py < V_VIS);
            e_r = e_blank ? Red_in   : 8'h00;
            e_g = e_blank ? Green_in : 8'h00;
            e_b = e_blank ? Blue_in  : 8'h00;
        end
        p = (t / CLK_DIV) % FRAME;
        e_vblank = (t % CLK_DIV == CLK_DIV - 1) && (p % H_TOT == H_TOT - 1) && (p / H_TOT == V_VIS - 1);
        prev_vblank = e_vblank;
        #1;
    endtask

    function automatic logic [48:0] exp_vec();
        int p;
        p = (t / CLK_DIV) % FRAME;
        return {10'(p % H_TOT), 10'(p / H_TOT), 1'((t % CLK_DIV) >= CLK_DIV / 2),
                e_hs, e_vs, e_blank, e_r, e_g, e_b, e_vblank};
    endfunction

    function automatic logic [48:0] act_vec();
        return {DrawX, DrawY, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, vblank_start};
    endfunction

    task automatic test_reset();
        Red_in = 8'hA5; Green_in = 8'h5A; Blue_in = 8'hC3;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, vblank_start} !== 6'b110000)
            $display("FAIL reset_ctrl: got %b expected 110000",
                     {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, vblank_start});
        else passed++;
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 24'h0) $display("FAIL reset_rgb: got %h expected 000000", {VGA_R, VGA_G, VGA_B});
        else passed++;
        checks++;
        if ({DrawX, DrawY} !== 20'h0) $display("FAIL reset_xy: got %0d,%0d expected 0,0", DrawX, DrawY);
        else passed++;
        Reset = 1'b0;
        model_reset();
        tick();
        checks++;
        if (DrawX !== 10'd0) $display("FAIL release_first_edge_x: got %0d expected 0", DrawX);
        else passed++;
        tick();
        checks++;
        if (DrawX !== 10'd1) $display("FAIL release_first_pe_x: got %0d expected 1", DrawX);
        else passed++;
        checks++;
        if (act_vec() !== exp_vec()) $display("FAIL release_pins: got %h expected %h", act_vec(), exp_vec());
        else passed++;
    endtask

    task automatic test_line();
        int t_x, t_fall, t_rise;
        logic hs_q;
        logic [9:0] x_q;
        t_x = -1; t_fall = -1; t_rise = -1;
        hs_q = VGA_HS; x_q = DrawX;
        for (int i = 0; i < 3 * H_TOT * CLK_DIV; i++) begin
            drive_rand();
            tick();
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL line t=%0d: got %h expected %h", t, act_vec(), exp_vec());
            else passed++;
            if (t_x < 0 && DrawX == 10'(HS_START) && x_q != 10'(HS_START)) t_x = t;
            if (t_x >= 0 && t_fall < 0 && hs_q && !VGA_HS) t_fall = t;
            if (t_fall >= 0 && t_rise < 0 && !hs_q && VGA_HS) t_rise = t;
            hs_q = VGA_HS; x_q = DrawX;
        end
        checks++;
        if (t_x < 0 || t_fall - t_x != CLK_DIV)
            $display("FAIL hs_fall_delay: got %0d expected %0d", t_fall - t_x, CLK_DIV);
        else passed++;
        checks++;
        if (t_fall < 0 || t_rise - t_fall != H_SW * CLK_DIV)
            $display("FAIL hs_low_width: got %0d expected %0d", t_rise - t_fall, H_SW * CLK_DIV);
        else passed++;
    endtask

    task automatic test_color();
        int r_ff, blank_nonzero;
        r_ff = 0; blank_nonzero = 0;
        Red_in = 8'hFF; Green_in = 8'h00; Blue_in = 8'h3F;
        for (int i = 0; i < CLK_DIV; i++) tick();
        for (int i = 0; i < FRAME * CLK_DIV; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL color t=%0d: got %h expected %h", t, act_vec(), exp_vec());
            else passed++;
            if (VGA_R == 8'hFF) r_ff++;
            if (!VGA_BLANK_N && {VGA_R, VGA_G, VGA_B} != 24'h0) blank_nonzero++;
        end
        checks++;
        if (r_ff != H_VIS * V_VIS * CLK_DIV)
            $display("FAIL color_red_cycles: got %0d expected %0d", r_ff, H_VIS * V_VIS * CLK_DIV);
        else passed++;
        checks++;
        if (blank_nonzero != 0) $display("FAIL color_blanked_rgb: got %0d expected 0", blank_nonzero);
        else passed++;
    endtask

    task automatic test_frame();
        int t_vfall, t_vrise, vs_y, t_p1, t_p2, pulses;
        logic vs_q;
        t_vfall = -1; t_vrise = -1; vs_y = -1; t_p1 = -1; t_p2 = -1; pulses = 0;
        vs_q = VGA_VS;
        for (int i = 0; i < 2 * FRAME * CLK_DIV + CLK_DIV; i++) begin
            drive_rand();
            tick();
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL frame t=%0d: got %h expected %h", t, act_vec(), exp_vec());
            else passed++;
            if (t_vfall < 0 && vs_q && !VGA_VS) begin t_vfall = t; vs_y = int'(DrawY); end
            if (t_vfall >= 0 && t_vrise < 0 && !vs_q && VGA_VS) t_vrise = t;
            vs_q = VGA_VS;
            if (vblank_start) begin
                pulses++;
                if (t_p1 < 0) t_p1 = t;
                else if (t_p2 < 0) t_p2 = t;
            end
        end
        checks++;
        if (vs_y != VS_START) $display("FAIL vs_start_line: got %0d expected %0d", vs_y, VS_START);
        else passed++;
        checks++;
        if (t_vrise < 0 || t_vrise - t_vfall != V_SW * H_TOT * CLK_DIV)
            $display("FAIL vs_low_width: got %0d expected %0d", t_vrise - t_vfall, V_SW * H_TOT * CLK_DIV);
        else passed++;
        checks++;
        if (pulses != 2) $display("FAIL vblank_pulse_count: got %0d expected 2", pulses);
        else passed++;
        checks++;
        if (t_p2 < 0 || t_p2 - t_p1 != FRAME * CLK_DIV)
            $display("FAIL vblank_period: got %0d expected %0d", t_p2 - t_p1, FRAME * CLK_DIV);
        else passed++;
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 1'b0;
        for (int i = 0; i < FRAME * CLK_DIV + 4 && !found; i++) begin
            drive_rand();
            tick();
            if (DrawX == 10'd9 && DrawY == 10'd5) found = 1'b1;
        end
        checks++;
        if (!found) $display("FAIL mid_reset_reach: got DrawX=%0d DrawY=%0d expected 9,5", DrawX, DrawY);
        else passed++;
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({DrawX, DrawY, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, vblank_start}
                !== {20'h0, 4'b0110, 24'h0, 1'b0})
            $display("FAIL mid_reset_async: got %h expected %h", act_vec(), {20'h0, 4'b0110, 24'h0, 1'b0});
        else passed++;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (act_vec() !== {20'h0, 4'b0110, 24'h0, 1'b0})
            $display("FAIL mid_reset_hold: got %h expected %h", act_vec(), {20'h0, 4'b0110, 24'h0, 1'b0});
        else passed++;
        Reset = 1'b0;
        model_reset();
        for (int i = 0; i < 2 * H_TOT * CLK_DIV; i++) begin
            drive_rand();
            tick();
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL restart t=%0d: got %h expected %h", t, act_vec(), exp_vec());
            else passed++;
        end
    endtask

`ifdef VGA_FRAME_COUNT_EN
    task automatic test_frame_count();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        model_reset();
        checks++;
        if (frame_count !== 16'd0) $display("FAIL frame_count_reset: got %0d expected 0", frame_count);
        else passed++;
        for (int i = 0; i < 4 * FRAME * CLK_DIV && e_fc < 3; i++) begin
            drive_rand();
            tick();
            checks++;
            if (frame_count !== 16'(e_fc)) $display("FAIL frame_count t=%0d: got %0d expected %0d", t, frame_count, e_fc);
            else passed++;
        end
        checks++;
        if (frame_count !== 16'd3) $display("FAIL frame_count_final: got %0d expected 3", frame_count);
        else passed++;
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_line();
        test_color();
        test_frame();
        test_mid_reset();
`ifdef VGA_FRAME_COUNT_EN
        test_frame_count();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
